// File: rtl/crc16_frame_arbiter.sv
// crc16_frame_arbiter
// Two-requester round-robin frame arbiter sharing one byte-parallel CRC-16
// engine. The granted source's bytes pass straight through to the output
// stream, and the CRC is appended as a two-byte trailer (high byte first).
module crc16_frame_arbiter #(
  parameter logic [15:0] CRC_INIT = 16'h0000,
  parameter logic [15:0] CRC_POLY = 16'h8005
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic        s0_last,
  input  logic [7:0]  s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic        s1_last,
  input  logic [7:0]  s1_data,
  output logic        s1_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        m_src,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CRC_HI = 2'd2,
    ST_CRC_LO = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_crc;
  logic        r_last_grant;
  logic        r_m_src;
  logic [15:0] r_frame_cnt;

  logic        w_g_valid;
  logic        w_g_last;
  logic [7:0]  w_g_data;
  logic        w_pick;
  logic        w_any_req;
  logic        w_data_xfer;

  // One byte of MSB-first CRC: fold the byte into the top of the register,
  // then run the eight shift/conditional-XOR steps unrolled.
  function automatic logic [15:0] crc_next(input logic [15:0] crc_in,
                                           input logic [7:0]  data_in);
    logic [15:0] c;
    c = crc_in ^ {data_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Select the granted source's stream and compute the arbitration pick.
  always_comb begin
    w_g_valid   = r_m_src ? s1_valid : s0_valid;
    w_g_last    = r_m_src ? s1_last  : s0_last;
    w_g_data    = r_m_src ? s1_data  : s0_data;
    w_any_req   = s0_valid | s1_valid;
    // Tie goes to whichever source was not granted last; otherwise the sole requester.
    if (s0_valid && s1_valid) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = s1_valid;
    end
    w_data_xfer = (r_state == ST_DATA) & w_g_valid & m_ready;
  end

  // Frame sequencer: grant, pass-through with CRC update, two-byte trailer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_crc        <= CRC_INIT;
      r_last_grant <= 1'b1;
      r_m_src      <= 1'b0;
      r_frame_cnt  <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_m_src <= w_pick;
            r_crc   <= CRC_INIT;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_data_xfer) begin
            r_crc <= crc_next(r_crc, w_g_data);
            if (w_g_last) begin
              r_state <= ST_CRC_HI;
            end
          end
        end
        ST_CRC_HI: begin
          if (m_ready) begin
            r_state <= ST_CRC_LO;
          end
        end
        ST_CRC_LO: begin
          if (m_ready) begin
            r_last_grant <= r_m_src;
            r_frame_cnt  <= r_frame_cnt + 16'h0001;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output stream and ready steering, decoded from the current state.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        m_valid = 1'b0;
      end
      ST_DATA: begin
        m_valid = w_g_valid;
        m_data  = w_g_data;
        if (r_m_src) begin
          s1_ready = m_ready;
        end else begin
          s0_ready = m_ready;
        end
      end
      ST_CRC_HI: begin
        m_valid = 1'b1;
        m_data  = r_crc[15:8];
      end
      ST_CRC_LO: begin
        m_valid = 1'b1;
        m_data  = r_crc[7:0];
        m_last  = 1'b1;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  assign m_src     = r_m_src;
  assign busy      = (r_state != ST_IDLE);
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_crc16_frame_arbiter.sv
// Directed testbench for crc16_frame_arbiter.
module tb_crc16_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s0_valid = 1'b0, s0_last = 1'b0;
  logic [7:0]  s0_data = 8'h00;
  logic        s0_ready;
  logic        s1_valid = 1'b0, s1_last = 1'b0;
  logic [7:0]  s1_data = 8'h00;
  logic        s1_ready;
  logic        m_valid, m_last, m_src, busy;
  logic [7:0]  m_data;
  logic        m_ready = 1'b1;
  logic [15:0] frame_cnt;

  crc16_frame_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_last(s0_last), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_last(s1_last), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .m_src(m_src), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source frame contents
  logic [7:0] f0 [0:15];
  logic [7:0] f1 [0:15];
  int         n0 = 0, n1 = 0;
  logic       nolast0 = 1'b0, gap0 = 1'b0;
  logic       rand_ready = 1'b0;

  // Captured output bytes (written only by the monitor)
  logic [7:0] act_d [0:255];
  logic       act_l [0:255];
  logic       act_s [0:255];
  int         wr = 0;
  int         rd = 0;
  int         mon_viol = 0;
  int         cyc = 0;

  // Expected output bytes
  logic [7:0] exp_d [0:63];
  logic       exp_l [0:63];
  logic       exp_s [0:63];
  int         exp_n = 0;

  logic       p_stall = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       p_last = 1'b0;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: held high or randomly toggled
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: capture accepted bytes, flag stall instability and illegal readies
  always @(negedge clk) begin
    if (!rst) begin
      p_stall <= 1'b0;
    end else begin
      mon_viol <= mon_viol
        + ((p_stall && !(m_valid && m_data == p_data && m_last == p_last)) ? 1 : 0)
        + ((busy && (m_src ? s0_ready : s1_ready)) ? 1 : 0)
        + ((s0_ready && s1_ready) ? 1 : 0);
      if (m_valid && m_ready) begin
        act_d[wr & 255] <= m_data;
        act_l[wr & 255] <= m_last;
        act_s[wr & 255] <= m_src;
        wr <= wr + 1;
      end
      p_stall <= m_valid && !m_ready;
      p_data  <= m_data;
      p_last  <= m_last;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference CRC: bit-serial feedback form
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb = c[15] ^ d[b];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic l, input logic s);
    exp_d[exp_n] = d; exp_l[exp_n] = l; exp_s[exp_n] = s;
    exp_n++;
  endtask

  task automatic exp_from(input logic src);
    logic [15:0] c;
    int n;
    logic [7:0] b;
    c = 16'h0000;
    n = src ? n1 : n0;
    for (int i = 0; i < n; i++) begin
      b = src ? f1[i] : f0[i];
      c = ref_crc(c, b);
      push_exp(b, 1'b0, src);
    end
    push_exp(c[15:8], 1'b0, src);
    push_exp(c[7:0], 1'b1, src);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, 32'(wr - rd), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (rd + i < wr)
        chk(tag, {21'd0, act_d[(rd + i) & 255], act_l[(rd + i) & 255], act_s[(rd + i) & 255], 1'b0},
                 {21'd0, exp_d[i], exp_l[i], exp_s[i], 1'b0});
    end
    rd = wr;
    exp_n = 0;
  endtask

  task automatic send0();
    int t;
    for (int i = 0; i < n0; i++) begin
      if (gap0 && i == 2) begin
        s0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
      s0_valid = 1'b1; s0_data = f0[i]; s0_last = (i == n0 - 1) && !nolast0;
      t = 0;
      do begin @(negedge clk); t++; end while (!s0_ready && t < 300);
      chk("src0_accept_timeout", 32'(t < 300), 32'd1);
      @(posedge clk); #1;
    end
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = 8'h00;
  endtask

  task automatic send1();
    int t;
    for (int i = 0; i < n1; i++) begin
      s1_valid = 1'b1; s1_data = f1[i]; s1_last = (i == n1 - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!s1_ready && t < 300);
      chk("src1_accept_timeout", 32'(t < 300), 32'd1);
      @(posedge clk); #1;
    end
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = 8'h00;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 500);
    chk("idle_timeout", 32'(t < 500), 32'd1);
  endtask

  task automatic load_check0();
    for (int i = 0; i < 9; i++) f0[i] = 8'h31 + 8'(i);
    n0 = 9;
  endtask

  initial begin
    int start;

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_m_valid", 32'(m_valid),   32'd0);
    chk("rst_ready",   32'({s0_ready, s1_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_m_src",     32'(m_src),     32'd0);
    chk("rst_m_last",    32'(m_last),    32'd0);
    @(posedge clk); #1;

    // ---- "123456789" from requester 0, m_ready held high ----
    load_check0();
    for (int i = 0; i < 9; i++) push_exp(8'h31 + 8'(i), 1'b0, 1'b0);
    push_exp(8'hFE, 1'b0, 1'b0);
    push_exp(8'hE8, 1'b1, 1'b0);
    start = cyc;
    send0();
    wait_idle();
    chk("check_cycles", 32'(cyc - start), 32'd12);
    check_frames("check_frame");
    chk("cnt_after_check", 32'(frame_cnt), 32'd1);
    @(posedge clk); #1;

    // ---- 1-byte frames from requester 1 ----
    f1[0] = 8'h01; n1 = 1;
    push_exp(8'h01, 1'b0, 1'b1); push_exp(8'h80, 1'b0, 1'b1); push_exp(8'h05, 1'b1, 1'b1);
    send1();
    wait_idle();
    check_frames("one_byte_01");
    @(posedge clk); #1;
    f1[0] = 8'h00; n1 = 1;
    push_exp(8'h00, 1'b0, 1'b1); push_exp(8'h00, 1'b0, 1'b1); push_exp(8'h00, 1'b1, 1'b1);
    send1();
    wait_idle();
    check_frames("one_byte_00");
    chk("cnt_after_one_byte", 32'(frame_cnt), 32'd3);
    @(posedge clk); #1;

    // ---- Both requesters continuously valid: grants alternate 0,1,0,1 ----
    f0[0] = 8'hA5; f0[1] = 8'h5A; n0 = 2;
    f1[0] = 8'h12; f1[1] = 8'h34; n1 = 2;
    exp_from(1'b0); exp_from(1'b1); exp_from(1'b0); exp_from(1'b1);
    fork
      begin send0(); send0(); end
      begin send1(); send1(); end
    join
    wait_idle();
    check_frames("alternate");
    chk("cnt_after_alt", 32'(frame_cnt), 32'd7);
    chk("mon_viol_alt", 32'(mon_viol), 32'd0);
    @(posedge clk); #1;

    // ---- Random m_ready stalls and source gaps ----
    load_check0();
    for (int i = 0; i < 9; i++) push_exp(8'h31 + 8'(i), 1'b0, 1'b0);
    push_exp(8'hFE, 1'b0, 1'b0);
    push_exp(8'hE8, 1'b1, 1'b0);
    rand_ready = 1'b1; gap0 = 1'b1;
    send0();
    wait_idle();
    rand_ready = 1'b0; gap0 = 1'b0;
    check_frames("stall_frame");
    chk("cnt_after_stall", 32'(frame_cnt), 32'd8);
    chk("mon_viol_stall", 32'(mon_viol), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // ---- Reset mid-frame after 4 bytes ----
    load_check0();
    n0 = 4; nolast0 = 1'b1;
    send0();
    rst = 1'b0;
    nolast0 = 1'b0;
    @(negedge clk);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_m_valid",   32'(m_valid),   32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_partial_bytes", 32'(wr - rd), 32'd4);
    rd = wr;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_trailer", 32'(wr - rd), 32'd0);
    load_check0();
    f1[0] = 8'h55; n1 = 1;
    exp_from(1'b0); exp_from(1'b1);
    fork
      send0();
      send1();
    join
    wait_idle();
    check_frames("after_reset");
    chk("cnt_after_reset", 32'(frame_cnt), 32'd2);
    @(posedge clk); #1;

    // ---- frame_cnt wrap ----
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(posedge clk); #1;
    chk("wrap_preload", 32'(frame_cnt), 32'h0000FFFF);
    f1[0] = 8'h00; n1 = 1;
    push_exp(8'h00, 1'b0, 1'b1); push_exp(8'h00, 1'b0, 1'b1); push_exp(8'h00, 1'b1, 1'b1);
    send1();
    wait_idle();
    check_frames("wrap_frame");
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("mon_viol_final", 32'(mon_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc16_frame_arbiter.md
# crc16_frame_arbiter

Two-requester frame arbiter and sequencer for the byte-parallel CRC-16 datapath. It grants one byte-stream source at a time (round-robin), forwards that source's frame bytes to a single output stream while updating a CRC-16 one byte per cycle, and appends the 16-bit CRC (high byte first) as the frame trailer. It sits between the packet sources and the serial/link transmitter, so that one CRC engine is shared by both sources.

## Interface
- `CRC_INIT`, 16'h0000, CRC register value loaded at each grant.
- `CRC_POLY`, 16'h8005, generator polynomial (x^16+x^15+x^2+1). Normal form, implicit x^16.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s0_valid`, `s0_last`  in  1  requester 0 byte valid / last byte of frame.
- `s0_data`  in  8  requester 0 byte.
- `s0_ready`  out  1  requester 0 byte accepted when `s0_valid & s0_ready`.
- `s1_valid`, `s1_last`, `s1_data`, `s1_ready`  as requester 0, for requester 1.
- `m_valid`  out  1  output byte valid.
- `m_data`  out  8  output byte.
- `m_last`  out  1  final byte of frame (low CRC byte).
- `m_ready`  in  1  downstream accepts byte when `m_valid & m_ready`.
- `m_src`  out  1  index of granted requester; meaningful while `busy`.
- `busy`  out  1  high in any state other than IDLE.
- `frame_cnt`  out  16  count of completed frames. Wraps 0xFFFF->0x0000.

## Operation
- CRC: MSB-first, no reflection, no final XOR. Per accepted byte `d`: crc_next = 8 serial steps of (crc ^ d<<8): shift left, XOR `CRC_POLY` when the shifted-out bit is 1. Computed combinationally as one byte-parallel step.
- States:
  - IDLE -> GRANT-DATA when any `sN_valid`.
  - DATA -> CRC_HI on an accepted byte with `sN_last`.
  - CRC_HI -> CRC_LO on `m_ready`.
  - CRC_LO -> IDLE on `m_ready`.
- IDLE:
  - All `sN_ready`=0, `m_valid`=0.
  - Arbitration: if only one source is valid, grant it. If both are valid, grant the source that is not `last_grant`.
  - On grant: register `m_src`, load crc <= `CRC_INIT`.
- DATA (pass-through, combinational):
  - `m_valid` = `s[g]_valid`, `m_data` = `s[g]_data`, `m_last` = 0, `s[g]_ready` = `m_ready`.
  - The non-granted ready is 0.
  - On each transfer: crc <= crc_next(crc, `s[g]_data`).
  - Source `last` is not forwarded.
- CRC_HI: `m_valid`=1, `m_data`=crc[15:8], `m_last`=0. Both readies are 0.
- CRC_LO: `m_valid`=1, `m_data`=crc[7:0], `m_last`=1. On acceptance: `last_grant` <= `m_src`, `frame_cnt` increments.
- A 1-byte frame (`last` on the first byte) is legal.
- The source controls gaps inside a frame (`s[g]_valid` low): no timeout, state holds.
- `m_valid`/`m_data` are stable while `m_ready`=0 in CRC states. In DATA, stability is inherited from the source.
- Reset (any time, including mid-frame):
  - state IDLE, crc=`CRC_INIT`, `last_grant`=1 (requester 0 wins first tie), `m_src`=0, `frame_cnt`=0.
  - All ready/valid/last outputs 0, `busy`=0.
  - A partial frame is abandoned; no CRC is emitted for it.

## Timing
- Grant latency: one cycle. A valid seen in IDLE at edge k produces `busy`=1 and a pass-through byte from cycle k+1.
- Throughput: one byte per cycle in DATA when source valid and `m_ready` are both held high.
- Trailer:
  - `m_valid` for CRC_HI is asserted in the cycle after the `last` transfer.
  - With `m_ready` held high, CRC_HI and CRC_LO take one cycle each.
  - IDLE lasts at least one cycle between frames.
- Minimum frame period: N+3 cycles for N data bytes (grant + N + 2 CRC).
- A new request arriving during a frame waits. The arbiter samples requests only in IDLE.
- `frame_cnt` updates on the edge that accepts the CRC_LO byte.

## Test plan
- Requester 0 sends ASCII "123456789", `m_ready`=1 -> output is the 9 bytes then 0xFE, 0xE8, with `m_last` on 0xE8 only. Total 12 cycles from first valid to IDLE. `frame_cnt`=1.
- 1-byte frame 0x01 from requester 1 -> output 0x01, 0x80, 0x05. Next, 1-byte frame 0x00 -> output 0x00, 0x00, 0x00.
- Both requesters hold valid continuously with 2-byte frames -> grants alternate 0,1,0,1. `m_src` matches on each frame. The non-granted ready is never 1.
- Random `m_ready` deassertion during DATA and CRC states -> no byte lost or duplicated. CRC bytes stay stable while stalled. CRC still 0xFEE8 for "123456789".
- Assert `rst` low mid-frame after 4 bytes, release, resend the full frame -> no trailer from the aborted frame. Correct CRC for the new frame. `frame_cnt` counts from 0. Requester 0 wins the first tie after reset.
- Preload by running 65536 frames (or force the counter to 0xFFFF) -> the next completed frame wraps `frame_cnt` to 0x0000.
